// File: rtl/wb_guard_pkg.sv
// Shared types and constants for the Wishbone timeout guard.
package wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2,
    HOLD = 2'd3
  } wb_state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBAD0_BAD0;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A clear coinciding with an increment still records that one event.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_timeout_guard.sv
// Wishbone pass-through that force-terminates a cycle the peripheral never acks,
// then blanks one cycle so a late ack cannot complete the next request.
module wb_timeout_guard
  import wb_guard_pkg::*;
#(
  parameter int               TIMEOUT_CYCLES = 255,
  parameter logic [DAT_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA,
  parameter int               CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             m_cyc_i,
  input  logic             m_stb_i,
  input  logic             m_we_i,
  input  logic [ADR_W-1:0] m_adr_i,
  input  logic [DAT_W-1:0] m_dat_i,
  input  logic [SEL_W-1:0] m_sel_i,
  output logic             m_ack_o,
  output logic [DAT_W-1:0] m_dat_o,
  output logic             p_cyc_o,
  output logic             p_stb_o,
  output logic             p_we_o,
  output logic [ADR_W-1:0] p_adr_o,
  output logic [DAT_W-1:0] p_dat_o,
  output logic [SEL_W-1:0] p_sel_o,
  input  logic             p_ack_i,
  input  logic [DAT_W-1:0] p_dat_i,
  input  logic             clr_count_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] timeout_count_o,
  output logic [1:0]       state_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e         state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic              req;
  logic              pass;

  // Handshake: a request is live while cyc&stb are high; it completes on the
  // cycle ack is high. The manager may abandon it by dropping cyc or stb.
  assign req  = m_cyc_i & m_stb_i;
  assign pass = (state_q == IDLE) || (state_q == WAIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && !p_ack_i) begin
            state_q    <= WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end
        end
        WAIT: begin
          if (p_ack_i || !req) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= ERR;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ERR:     state_q <= HOLD;
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates the request and response paths asynchronously.
  assign p_cyc_o = nRST & pass & m_cyc_i;
  assign p_stb_o = nRST & pass & m_stb_i;
  assign p_we_o  = m_we_i;
  assign p_adr_o = m_adr_i;
  assign p_dat_o = m_dat_i;
  assign p_sel_o = m_sel_i;

  assign m_ack_o = nRST & ((pass & p_ack_i & req) | (state_q == ERR));
  assign m_dat_o = !nRST ? '0 : ((state_q == ERR) ? ERR_DATA : p_dat_i);

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_timeout_cnt (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .clr_i  (clr_count_i),
    .inc_i  (timeout_q),
    .count_o(timeout_count_o)
  );

endmodule
